// File: rtl/common_fifo_buffer.sv
// Synchronous valid/ready FIFO stage that decouples consumer back-pressure from the upstream arbiter.
// Define COMMON_FIFO_BUFFER_FULL_PASSTHROUGH_EN to accept a write while full if the head is popping in the same cycle.
module common_fifo_buffer #(
  parameter int unsigned BUFFER_WIDTH      = 1,
  parameter int unsigned BUFFER_DEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BUFFER_WIDTH-1:0]      prev_i_data,
  input  logic                         prev_i_valid,
  output logic                         prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]      next_o_data,
  output logic                         next_o_valid,
  input  logic                         next_i_ready,
  output logic [BUFFER_DEPTH_LOG2:0]   o_count
);

  localparam int unsigned PTR_W = BUFFER_DEPTH_LOG2;
  localparam int unsigned CNT_W = BUFFER_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << BUFFER_DEPTH_LOG2;

  logic [BUFFER_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Ready decodes only the registered count, unless passthrough lets a same-cycle pop free the slot.
`ifdef COMMON_FIFO_BUFFER_FULL_PASSTHROUGH_EN
  assign prev_o_ready = ~full | next_i_ready;
`else
  assign prev_o_ready = ~full;
`endif

  assign next_o_valid = ~empty;
  assign next_o_data  = mem_q[rd_ptr_q] & {BUFFER_WIDTH{next_o_valid}};
  assign o_count      = count_q;

  assign push = prev_i_valid & prev_o_ready;
  assign pop  = next_o_valid & next_i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left unreset; the AND gate on next_o_data hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= prev_i_data;
  end

endmodule

// File: tb/tb_common_fifo_buffer.sv
// Scoreboard bench for common_fifo_buffer (WIDTH=8, DEPTH=4) with directed vectors.
module tb_common_fifo_buffer;

`ifdef COMMON_FIFO_BUFFER_FULL_PASSTHROUGH_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] prev_i_data = '0;
  logic       prev_i_valid = 1'b0;
  logic       prev_o_ready;
  logic [7:0] next_o_data;
  logic       next_o_valid;
  logic       next_i_ready = 1'b0;
  logic [2:0] o_count;

  int n_cmp = 0;
  int n_fail = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  common_fifo_buffer #(.BUFFER_WIDTH(8), .BUFFER_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid), .prev_o_ready(prev_o_ready),
    .next_o_data(next_o_data), .next_o_valid(next_o_valid), .next_i_ready(next_i_ready),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every head handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && next_o_valid && next_i_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", next_o_data, $time);
      end else begin
        chk("pop_data", 32'(next_o_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_state();
    chk("count", 32'(o_count), 32'(model_count));
    chk("valid", 32'(next_o_valid), 32'(model_count != 0));
    chk("ready", 32'(prev_o_ready), 32'(model_count < 4 || (PT && next_i_ready)));
  endtask

  // One clock of stimulus; the bench model decides acceptance and queues expected data.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit acc, pp;
    prev_i_valid = v;
    prev_i_data  = d;
    next_i_ready = r;
    acc = v && (model_count < 4 || (PT && r));
    pp  = r && (model_count > 0);
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    model_count = model_count + (acc ? 1 : 0) - (pp ? 1 : 0);
    prev_i_valid = 1'b0;
    next_i_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && model_count > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check_state();
  endtask

  initial begin
    // Reset held across several edges, then released.
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_state();
    chk("reset_data", 32'(next_o_data), 32'h00);

    // Ordering and first-push latency.
    cycle(1'b1, 8'h11, 1'b0);
    chk("head_after_first", 32'(next_o_data), 32'h11);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    chk("count3", 32'(o_count), 32'd3);
    drain();

    // Fill to full, then a refused write held for 3 cycles.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("full_count", 32'(o_count), 32'd4);
    chk("full_ready", 32'(prev_o_ready), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA4, 1'b0);
    check_state();
    drain();

    // Wrap-around: 10 rounds of push 2 / pop 2.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'(2 * k), 1'b0);
      cycle(1'b1, 8'(2 * k + 1), 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk("wrap_count", 32'(o_count), 32'd0);

    // Simultaneous push/pop at count=2.
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h20, 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    chk("simul_count", 32'(o_count), 32'd2);
    chk("simul_head", 32'(next_o_data), 32'h20);
    drain();

    // Full plus pop with a write offered.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    chk("fullpop_count", 32'(o_count), PT ? 32'd4 : 32'd3);
    check_state();
    drain();

    // Asynchronous reset between edges at count=3.
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(next_o_valid), 32'd0);
    chk("async_count", 32'(o_count), 32'd0);
    exp_q.delete();
    model_count = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    check_state();
    cycle(1'b1, 8'h99, 1'b0);
    chk("post_reset_head", 32'(next_o_data), 32'h99);
    check_state();
    drain();

    @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/common_fifo_buffer.md
Name: common_fifo_buffer

Overview:
- Synchronous FIFO stage downstream of the 4-to-1 cross buffer; absorbs its arbitrated output stream and decouples the consumer's back-pressure from the arbiter.
- Uses the same valid/ready handshake as the other common buffers.
- prev_o_ready is a registered status, so the arbiter's valid (which is gated by ready) never forms a combinational loop through this block.

Parameters:
- BUFFER_WIDTH, 1, data width in bits.
- BUFFER_DEPTH_LOG2, 2, log2 of entry count; DEPTH = 2**BUFFER_DEPTH_LOG2; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- prev_i_data  input  BUFFER_WIDTH  write data.
- prev_i_valid  input  1  write request.
- prev_o_ready  output  1  FIFO can accept a write.
- next_o_data  output  BUFFER_WIDTH  head entry.
- next_o_valid  output  1  head entry present.
- next_i_ready  input  1  consumer accepts head.
- o_count  output  BUFFER_DEPTH_LOG2+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous, active-low (reset=0 clears state immediately, independent of clk). Cleared on reset: wr_ptr, rd_ptr, count. After reset: o_count=0, next_o_valid=0, prev_o_ready=1, next_o_data=0. Storage array is not reset.
- Reset asserted mid-operation discards all stored entries. No handshake completes in that cycle.
- push = prev_i_valid & prev_o_ready; pop = next_o_valid & next_i_ready.
- Pointers are BUFFER_DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
- count is BUFFER_DEPTH_LOG2+1 bits, with no wrap:
  - push only: +1.
  - pop only: -1.
  - push and pop together, or neither: unchanged.
- empty = (count==0); full = (count==DEPTH).
- next_o_valid = ~empty.
- prev_o_ready = ~full, derived from registered count only; no dependence on next_i_ready or prev_i_valid.
- next_o_data = mem[rd_ptr] when ~empty, else all-zero (AND-gated).
- Latency: a pushed entry is visible at next_o_data/next_o_valid in the cycle after the push edge. There is no same-cycle bypass when empty.
- Full: writes are refused. prev_i_valid may stay high with no effect. A pop in that cycle makes prev_o_ready=1 next cycle.
- Empty: next_i_ready is ignored.
- Simultaneous push and pop at 0<count<DEPTH: both pointers advance, count holds, and the write does not disturb the head being read.
- Data ordering is strictly FIFO; no entry is lost or duplicated.
- Throughput: 1 entry/cycle sustained when 0<count<DEPTH.

Optional Feature:
- Macro: COMMON_FIFO_BUFFER_FULL_PASSTHROUGH_EN.
- Defined: prev_o_ready = ~full | next_i_ready. When full and the consumer pops, a simultaneous push is accepted, count stays DEPTH, and throughput is 1/cycle at full. The ready path becomes combinational from next_i_ready; the integrator must ensure the consumer's ready does not depend on next_o_valid.
- Undefined: prev_o_ready = ~full (registered path only). Full plus pop yields a one-cycle write bubble.

Test Plan:
- Reset and ordering (WIDTH=8, DEPTH=4): hold reset=0 mid-stream, then release. Expect o_count=0, next_o_valid=0, prev_o_ready=1, next_o_data=0x00. Push 0x11,0x22,0x33 on consecutive cycles with next_i_ready=0. Expect o_count=3 and head 0x11 one cycle after the first push.
- Fill to full: push 0xA0..0xA3. Expect o_count=4 and prev_o_ready=0. A fifth push of 0xA4 held valid for 3 cycles is not accepted. Draining then yields exactly 0xA0,0xA1,0xA2,0xA3.
- Wrap-around: 10 rounds of push 2/pop 2 (pointers wrap ≥4 times). Output sequence equals input sequence 0x00..0x13 and o_count returns to 0.
- Simultaneous push/pop at count=2: push 0x55 while popping head 0x10. Expect o_count stays 2 and the next head is the entry previously second.
- Full + pop: with count=4, assert next_i_ready and prev_i_valid with 0x77.
  - Macro undefined: 0x77 not accepted and o_count=3 next cycle.
  - Macro defined: 0x77 accepted and o_count stays 4.
- Async reset mid-operation: drop reset between clock edges at count=3. Expect next_o_valid=0 and o_count=0 before the next clk edge; the first push after release appears as the head.
